// File: rtl/hist_pkg.sv
// Shared constants and state encoding for the histogram-building pass.
package hist_pkg;

    localparam int unsigned NUM_BINS        = 256;
    localparam int unsigned PIXEL_W         = 8;
    localparam int unsigned PIXELS_PER_WORD = 16;
    localparam int unsigned COUNT_W         = 32;
    localparam int unsigned MEM_DATA_W      = 128;
    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned PIX_IDX_W       = 4;
    localparam int unsigned CTR_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_ACCUM,
        ST_DRAIN,
        ST_DONE
    } hist_accum_state_t;

endpackage

// File: rtl/hist_rmw_stage.sv
// Write half of the bin read-modify-write: one cycle behind the read, forwarding
// the previous count when the same bin is hit twice in a row.
module hist_rmw_stage
    import hist_pkg::*;
#(
    parameter logic [ADDR_W-1:0] HIST_BASE = 16'h0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid_i,
    input  logic [PIXEL_W-1:0]    in_bin_i,
    input  logic [COUNT_W-1:0]    rd_count_i,
    output logic                  wr_en_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic [MEM_DATA_W-1:0] wr_data_o
);

    logic               vld_q;
    logic               last_vld_q;
    logic [PIXEL_W-1:0] bin_q;
    logic [PIXEL_W-1:0] last_bin_q;
    logic [COUNT_W-1:0] last_cnt_q;
    logic [COUNT_W-1:0] cnt_d;
    logic               fwd_hit;

    // Memory returns stale data when the previous write targets the same bin.
    always_comb begin
        fwd_hit = last_vld_q && (last_bin_q == bin_q);
        cnt_d   = fwd_hit ? (last_cnt_q + COUNT_W'(1)) : (rd_count_i + COUNT_W'(1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q      <= 1'b0;
            last_vld_q <= 1'b0;
            bin_q      <= '0;
            last_bin_q <= '0;
            last_cnt_q <= '0;
        end else begin
            vld_q      <= in_valid_i;
            bin_q      <= in_bin_i;
            last_vld_q <= vld_q;
            last_bin_q <= bin_q;
            if (vld_q) begin
                last_cnt_q <= cnt_d;
            end
        end
    end

    always_comb begin
        wr_en_o   = vld_q;
        wr_addr_o = vld_q ? (HIST_BASE + ADDR_W'(bin_q)) : '0;
        wr_data_o = vld_q ? MEM_DATA_W'(cnt_d) : '0;
    end

endmodule

// File: rtl/histogram_accum_ctrl.sv
// Histogram pass sequencer: clears 256 bins, then streams pixel words and
// issues one bin read-modify-write per pixel per cycle.
module histogram_accum_ctrl
    import hist_pkg::*;
#(
    parameter int unsigned       NUM_WORDS  = 4096,
    parameter logic [ADDR_W-1:0] INPUT_BASE = 16'h0000,
    parameter logic [ADDR_W-1:0] HIST_BASE  = 16'h0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_histogram,
    output logic                  busy,
    output logic                  histogram_done,
    output logic [ADDR_W-1:0]     input_read_addr1,
    input  logic [MEM_DATA_W-1:0] input_rdata1,
    output logic [ADDR_W-1:0]     scratch_read_addr1,
    input  logic [MEM_DATA_W-1:0] scratch_rdata1,
    output logic                  scratch_WE,
    output logic [ADDR_W-1:0]     scratch_write_addr,
    output logic [MEM_DATA_W-1:0] scratch_wdata
);

    localparam int unsigned      WORD_IDX_W = CTR_W - PIX_IDX_W;
    localparam logic [CTR_W-1:0] LAST_PIX   = CTR_W'(NUM_WORDS * PIXELS_PER_WORD - 1);
    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(NUM_WORDS - 1);

    hist_accum_state_t     state_q;
    logic [CTR_W-1:0]      ctr_q;
    logic [MEM_DATA_W-1:0] word_q;

    logic [PIX_IDX_W-1:0]  pix_sel;
    logic [WORD_IDX_W-1:0] word_idx;
    logic [MEM_DATA_W-1:0] word_src;
    logic [PIXEL_W-1:0]    pix_c;
    logic                  rmw_valid;
    logic                  rmw_we;
    logic [ADDR_W-1:0]     rmw_addr;
    logic [MEM_DATA_W-1:0] rmw_data;
    logic                  unused_rdata_hi;

    assign unused_rdata_hi = ^scratch_rdata1[MEM_DATA_W-1:COUNT_W];

    // Pixel 0 of each word comes straight off the memory bus; the rest from the latch.
    always_comb begin
        pix_sel  = ctr_q[PIX_IDX_W-1:0];
        word_idx = ctr_q[CTR_W-1:PIX_IDX_W];
        word_src = (pix_sel == '0) ? input_rdata1 : word_q;
        pix_c    = word_src[{pix_sel, 3'b000} +: PIXEL_W];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ctr_q   <= '0;
            word_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ctr_q <= '0;
                    if (start_histogram) begin
                        state_q <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (ctr_q[PIXEL_W-1:0] == 8'hFF) begin
                        state_q <= ST_FETCH;
                        ctr_q   <= '0;
                    end else begin
                        ctr_q <= ctr_q + CTR_W'(1);
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_ACCUM;
                    ctr_q   <= '0;
                end
                ST_ACCUM: begin
                    if (pix_sel == '0) begin
                        word_q <= input_rdata1;
                    end
                    if (ctr_q == LAST_PIX) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        ctr_q <= ctr_q + CTR_W'(1);
                    end
                end
                ST_DRAIN: state_q <= ST_DONE;
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    hist_rmw_stage #(
        .HIST_BASE(HIST_BASE)
    ) u_rmw (
        .clock      (clock),
        .reset      (reset),
        .in_valid_i (rmw_valid),
        .in_bin_i   (pix_c),
        .rd_count_i (scratch_rdata1[COUNT_W-1:0]),
        .wr_en_o    (rmw_we),
        .wr_addr_o  (rmw_addr),
        .wr_data_o  (rmw_data)
    );

    // Port decode; the write port belongs to the clear sweep or the RMW stage.
    always_comb begin
        busy               = (state_q != ST_IDLE);
        histogram_done     = (state_q == ST_DONE);
        rmw_valid          = (state_q == ST_ACCUM);
        input_read_addr1   = '0;
        scratch_read_addr1 = '0;
        scratch_WE         = rmw_we;
        scratch_write_addr = rmw_addr;
        scratch_wdata      = rmw_data;
        case (state_q)
            ST_CLEAR: begin
                scratch_WE         = 1'b1;
                scratch_write_addr = HIST_BASE + ADDR_W'(ctr_q[PIXEL_W-1:0]);
                scratch_wdata      = '0;
            end
            ST_FETCH: input_read_addr1 = INPUT_BASE;
            ST_ACCUM: begin
                scratch_read_addr1 = HIST_BASE + ADDR_W'(pix_c);
                if ((pix_sel == 4'hF) && (word_idx != LAST_WORD)) begin
                    input_read_addr1 = INPUT_BASE + ADDR_W'(word_idx) + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule
